// File: rtl/dual_issue_scheduler.sv
// -----------------------------------------------------------------------------
// dual_issue_scheduler
//
// Issue stage for a two-wide in-order RV32I pipeline. Each cycle it looks at
// the two oldest instructions in the fetch buffer. It then does one of three
// things:
//   - issues both instructions,
//   - issues only the oldest one, or
//   - stalls.
// The choice depends on pairwise hazards, execute-stage backpressure and a
// one-entry load-use scoreboard.
//
// Parameters
//   LOAD_LATENCY        cycles a LOAD result is unavailable after issue (1-7)
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   nothing_filled      fetch buffer is empty
//   instruction0        oldest buffered instruction
//   instruction1        next instruction, 32'h0 marks an empty slot
//   exec_ready          execute stage accepts an issue this cycle
//   freeze1             (comb) fetch buffer must hold, nothing issues
//   freeze2             (comb) the stall is caused by backpressure
//   dependency_on_ins2  (comb) only instruction0 issues, buffer slides by one
//   issue0_valid/instr  (reg) lane-0 issue, always carries instruction0
//   issue1_valid/instr  (reg) lane-1 issue, carries instruction1 on dual issue
// -----------------------------------------------------------------------------
module dual_issue_scheduler #(
    parameter int unsigned LOAD_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        exec_ready,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // A write to x0 is discarded, so it never counts as a destination.
    function automatic logic writes_rd(input logic [31:0] ins);
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_IMM, OP_OP:          writes_rd = (ins[11:7] != 5'd0);
            default:                         writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        case (ins[6:0])
            OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP:         reads_rs1 = 1'b1;
            default:                         reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        case (ins[6:0])
            OP_BRANCH, OP_STORE, OP_OP:      reads_rs2 = 1'b1;
            default:                         reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        is_mem = (ins[6:0] == OP_LOAD) || (ins[6:0] == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [31:0] ins);
        is_ctrl = (ins[6:0] == OP_BRANCH) || (ins[6:0] == OP_JAL) ||
                  (ins[6:0] == OP_JALR);
    endfunction

    // Load scoreboard: destination of the most recent load and the cycles left
    // before its result can be consumed.
    logic [4:0]  pending_rd_q, pending_rd_d;
    logic [2:0]  load_cnt_q,   load_cnt_d;

    logic        issue0_valid_q, issue0_valid_d;
    logic [31:0] issue0_instr_q, issue0_instr_d;
    logic        issue1_valid_q, issue1_valid_d;
    logic [31:0] issue1_instr_q, issue1_instr_d;

    logic load_pending;
    assign load_pending = (load_cnt_q != 3'd0);

    // An instruction touches the busy register if it reads it, or if it
    // writes it. pending_rd is never x0 while a load is pending, so the x0
    // guard only matters for the reads.
    function automatic logic touches_busy(input logic [31:0] ins,
                                          input logic        pend,
                                          input logic [4:0]  prd);
        touches_busy = pend && (
            (reads_rs1(ins) && ins[19:15] != 5'd0 && ins[19:15] == prd) ||
            (reads_rs2(ins) && ins[24:20] != 5'd0 && ins[24:20] == prd) ||
            (writes_rd(ins) && ins[11:7] == prd));
    endfunction

    logic ins0_stall;
    logic pair_conflict;

    assign ins0_stall = touches_busy(instruction0, load_pending, pending_rd_q) ||
                        (is_mem(instruction0) && load_pending);

    assign pair_conflict =
        (writes_rd(instruction0) && (
            (reads_rs1(instruction1) && instruction1[19:15] == instruction0[11:7]) ||
            (reads_rs2(instruction1) && instruction1[24:20] == instruction0[11:7]) ||
            (writes_rd(instruction1) && instruction1[11:7]  == instruction0[11:7]))) ||
        is_ctrl(instruction0) ||
        (is_mem(instruction0) && is_mem(instruction1)) ||
        touches_busy(instruction1, load_pending, pending_rd_q);

    logic issue0, issue1;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        issue0             = 1'b0;
        issue1             = 1'b0;
        if (rst || nothing_filled) begin
            // Idle: all controls low, nothing issues.
        end else if (!exec_ready) begin
            freeze1 = 1'b1;
            freeze2 = 1'b1;
        end else if (ins0_stall) begin
            freeze1 = 1'b1;
        end else if (instruction1 == 32'h0) begin
            issue0 = 1'b1;
        end else if (pair_conflict) begin
            dependency_on_ins2 = 1'b1;
            issue0             = 1'b1;
        end else begin
            issue0 = 1'b1;
            issue1 = 1'b1;
        end
    end

    always_comb begin
        issue0_valid_d = issue0;
        issue0_instr_d = issue0 ? instruction0 : 32'h0;
        issue1_valid_d = issue1;
        issue1_instr_d = issue1 ? instruction1 : 32'h0;

        // Two loads can never dual issue (single memory port), so checking
        // lane 0 first covers every case.
        pending_rd_d = pending_rd_q;
        load_cnt_d   = load_pending ? load_cnt_q - 3'd1 : 3'd0;
        if (issue0 && instruction0[6:0] == OP_LOAD && instruction0[11:7] != 5'd0) begin
            pending_rd_d = instruction0[11:7];
            load_cnt_d   = 3'(LOAD_LATENCY);
        end else if (issue1 && instruction1[6:0] == OP_LOAD && instruction1[11:7] != 5'd0) begin
            pending_rd_d = instruction1[11:7];
            load_cnt_d   = 3'(LOAD_LATENCY);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue0_valid_q <= 1'b0;
            issue0_instr_q <= 32'h0;
            issue1_valid_q <= 1'b0;
            issue1_instr_q <= 32'h0;
            pending_rd_q   <= 5'd0;
            load_cnt_q     <= 3'd0;
        end else begin
            issue0_valid_q <= issue0_valid_d;
            issue0_instr_q <= issue0_instr_d;
            issue1_valid_q <= issue1_valid_d;
            issue1_instr_q <= issue1_instr_d;
            pending_rd_q   <= pending_rd_d;
            load_cnt_q     <= load_cnt_d;
        end
    end

    assign issue0_valid = issue0_valid_q;
    assign issue0_instr = issue0_instr_q;
    assign issue1_valid = issue1_valid_q;
    assign issue1_instr = issue1_instr_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_scheduler
//
// Directed bench for dual_issue_scheduler with LOAD_LATENCY = 3.
// - Combinational controls are checked in the same cycle that drives them.
// - Each expected registered issue is pushed into a queue by the stimulus.
// - A monitor on the falling edge pops and compares that entry whenever a
//   lane is valid.
// - Idle lanes are checked for zero instructions.
// -----------------------------------------------------------------------------
module tb_dual_issue_scheduler;

    localparam logic [31:0] ADDI_X1_5   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] ADDI_X2_7   = 32'h00700113; // addi x2,x0,7
    localparam logic [31:0] ADDI_X1_7   = 32'h00700093; // addi x1,x0,7
    localparam logic [31:0] ADD_X3_X1   = 32'h001081B3; // add  x3,x1,x1
    localparam logic [31:0] LW_X5       = 32'h00002283; // lw   x5,0(x0)
    localparam logic [31:0] ADD_X6_X5   = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] SW_X2       = 32'h00202223; // sw   x2,4(x0)
    localparam logic [31:0] BEQ_X1_X2   = 32'h00208463; // beq  x1,x2,8

    logic        clk = 1'b0;
    logic        rst;
    logic        nothing_filled;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        exec_ready;
    logic        freeze1;
    logic        freeze2;
    logic        dependency_on_ins2;
    logic        issue0_valid;
    logic [31:0] issue0_instr;
    logic        issue1_valid;
    logic [31:0] issue1_instr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [65:0] exp_q[$];

    always #5 clk = ~clk;

    dual_issue_scheduler #(.LOAD_LATENCY(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .nothing_filled     (nothing_filled),
        .instruction0       (instruction0),
        .instruction1       (instruction1),
        .exec_ready         (exec_ready),
        .freeze1            (freeze1),
        .freeze2            (freeze2),
        .dependency_on_ins2 (dependency_on_ins2),
        .issue0_valid       (issue0_valid),
        .issue0_instr       (issue0_instr),
        .issue1_valid       (issue1_valid),
        .issue1_instr       (issue1_instr)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [65:0] pack(input logic v0, input logic [31:0] i0,
                                         input logic v1, input logic [31:0] i1);
        pack = {v0, i0, v1, i1};
    endfunction

    // Runs one cycle: drive inputs, check {freeze1,freeze2,dependency_on_ins2},
    // optionally record the issue expected after the coming edge.
    task automatic cycle(input string name, input logic nf, input logic er,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [2:0] exp_ctrl,
                         input logic push_en, input logic [65:0] exp_issue);
        nothing_filled = nf;
        exec_ready     = er;
        instruction0   = i0;
        instruction1   = i1;
        #1;
        check({name, " ctrl"}, {63'd0, freeze1, freeze2, dependency_on_ins2},
              {63'd0, exp_ctrl});
        if (push_en) exp_q.push_back(exp_issue);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares registered issue outputs against the scoreboard.
    always @(negedge clk) begin
        if (issue0_valid || issue1_valid) begin
            if (exp_q.size() == 0)
                check("unexpected issue",
                      pack(issue0_valid, issue0_instr, issue1_valid, issue1_instr), 66'd0);
            else
                check("issue",
                      pack(issue0_valid, issue0_instr, issue1_valid, issue1_instr),
                      exp_q.pop_front());
        end else begin
            check("idle lanes", {2'b00, issue0_instr, issue1_instr}, 66'd0);
        end
    end

    initial begin
        // Reset with an issuable pair present: everything must stay low.
        rst = 1'b1;
        nothing_filled = 1'b0;
        exec_ready     = 1'b1;
        instruction0   = ADDI_X1_5;
        instruction1   = ADDI_X2_7;
        @(posedge clk);
        #1;
        check("reset ctrl", {63'd0, freeze1, freeze2, dependency_on_ins2}, 66'd0);
        @(posedge clk);
        #1;
        check("reset regs", pack(issue0_valid, issue0_instr, issue1_valid, issue1_instr), 66'd0);
        rst = 1'b0;

        cycle("dual", 0, 1, ADDI_X1_5, ADDI_X2_7, 3'b000, 1, pack(1, ADDI_X1_5, 1, ADDI_X2_7));
        cycle("raw",  0, 1, ADDI_X1_5, ADD_X3_X1, 3'b001, 1, pack(1, ADDI_X1_5, 0, 32'h0));
        cycle("waw",  0, 1, ADDI_X1_5, ADDI_X1_7, 3'b001, 1, pack(1, ADDI_X1_5, 0, 32'h0));

        // Backpressure holds the pair, then it dual issues.
        cycle("bp0",     0, 0, ADDI_X1_5, ADDI_X2_7, 3'b110, 0, 66'd0);
        cycle("bp1",     0, 0, ADDI_X1_5, ADDI_X2_7, 3'b110, 0, 66'd0);
        cycle("bp done", 0, 1, ADDI_X1_5, ADDI_X2_7, 3'b000, 1, pack(1, ADDI_X1_5, 1, ADDI_X2_7));

        // Load-use: lw issues at edge T, dependent stalls three cycles,
        // then issues once load_cnt reaches zero.
        cycle("lw",      0, 1, LW_X5,     32'h0, 3'b000, 1, pack(1, LW_X5, 0, 32'h0));
        cycle("luse s1", 0, 1, ADD_X6_X5, 32'h0, 3'b100, 0, 66'd0);
        cycle("luse s2", 0, 1, ADD_X6_X5, 32'h0, 3'b100, 0, 66'd0);
        cycle("luse s3", 0, 1, ADD_X6_X5, 32'h0, 3'b100, 0, 66'd0);
        cycle("luse go", 0, 1, ADD_X6_X5, 32'h0, 3'b000, 1, pack(1, ADD_X6_X5, 0, 32'h0));

        // Busy register in instruction1 only splits the pair.
        cycle("lw b",      0, 1, LW_X5,     32'h0,     3'b000, 1, pack(1, LW_X5, 0, 32'h0));
        cycle("ins1 busy", 0, 1, ADDI_X1_5, ADD_X6_X5, 3'b001, 1, pack(1, ADDI_X1_5, 0, 32'h0));
        cycle("drain0",    1, 1, ADDI_X1_5, ADDI_X2_7, 3'b000, 0, 66'd0);
        cycle("drain1",    1, 1, ADDI_X1_5, ADDI_X2_7, 3'b000, 0, 66'd0);

        // Structural: one memory port, and no pairing behind a branch.
        cycle("lw/sw",  0, 1, LW_X5,     SW_X2,     3'b001, 1, pack(1, LW_X5, 0, 32'h0));
        cycle("beq",    0, 1, BEQ_X1_X2, ADDI_X1_5, 3'b001, 1, pack(1, BEQ_X1_X2, 0, 32'h0));
        cycle("empty",  1, 1, BEQ_X1_X2, ADDI_X1_5, 3'b000, 0, 66'd0);
        // load_cnt is 1 here: a memory op in lane 0 must still wait.
        cycle("mem wait", 0, 1, SW_X2, 32'h0, 3'b100, 0, 66'd0);
        cycle("mem go",   0, 1, SW_X2, 32'h0, 3'b000, 1, pack(1, SW_X2, 0, 32'h0));

        // Reset while load_cnt == 2 clears the scoreboard.
        cycle("lw r",    0, 1, LW_X5,     32'h0, 3'b000, 1, pack(1, LW_X5, 0, 32'h0));
        cycle("rl s1",   0, 1, ADD_X6_X5, 32'h0, 3'b100, 0, 66'd0);
        rst = 1'b1;
        #1;
        check("mid rst ctrl", {63'd0, freeze1, freeze2, dependency_on_ins2}, 66'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("rl go",   0, 1, ADD_X6_X5, 32'h0, 3'b000, 1, pack(1, ADD_X6_X5, 0, 32'h0));

        cycle("tail0", 1, 1, 32'h0, 32'h0, 3'b000, 0, 66'd0);
        cycle("tail1", 1, 1, 32'h0, 32'h0, 3'b000, 0, 66'd0);
        check("scoreboard drained", 66'(exp_q.size()), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
